// File: rtl/uart_reg_controller_pkg.sv
// Shared structures for the UART register bridge: the UART_PACKET stream type,
// command opcodes and the controller state encoding.
package uart_reg_controller_pkg;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;

  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddress,
    StGetData,
    StGetCount,
    StDiscard,
    StReadReq,
    StReadWait,
    StSendResp
  } state_e;

endpackage

// File: rtl/uart_reg_controller_tx_serialiser.sv
// Turns one register word into DATA_BYTES UART_PACKET bytes, MSB first, held
// until ipTxReady. Used only when UART_REG_READ_EN is defined.
module uart_tx_serialiser
  import uart_reg_controller_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [7:0]  CHANNEL    = 8'h01
) (
  input  logic                    ipClk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [8*DATA_BYTES-1:0] word_i,
  input  logic                    sop_i,
  input  logic                    eop_i,
  input  logic [7:0]              length_i,
  input  logic                    ipTxReady,
  output UART_PACKET              opTxStream,
  output logic                    done_o
);

  localparam int unsigned W    = 8 * DATA_BYTES;
  localparam int unsigned IdxW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [W-1:0]    word_q, word_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
  logic [7:0]      len_q, len_d, src_q, src_d;
  logic            last_byte;

  assign last_byte = (idx_q == IdxW'(DATA_BYTES - 1));

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    valid_d = valid_q;
    len_d   = len_q;
    src_d   = src_q;
    done_o  = 1'b0;
    if (load_i) begin
      word_d  = word_i;
      idx_d   = '0;
      sop_d   = sop_i;
      eop_d   = eop_i;
      valid_d = 1'b1;
      len_d   = length_i;
      src_d   = CHANNEL;
    end else if (valid_q && ipTxReady) begin
      word_d = word_q << 8;
      if (last_byte) begin
        valid_d = 1'b0;
        done_o  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      word_q  <= '0;
      idx_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
      len_q   <= '0;
      src_q   <= '0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    opTxStream             = '0;
    opTxStream.Source      = src_q;
    opTxStream.Destination = 8'h00;
    opTxStream.Length      = len_q;
    opTxStream.Data        = word_q[W-1 -: 8];
    opTxStream.Valid       = valid_q;
    opTxStream.SoP         = valid_q && sop_q && (idx_q == '0);
    opTxStream.EoP         = valid_q && eop_q && last_byte;
  end

endmodule

// File: rtl/uart_reg_controller.sv
// UART packet to register-bus bridge with auto-incrementing burst writes.
// Define UART_REG_READ_EN to compile in burst reads and the response stream.
module uart_reg_controller
  import uart_reg_controller_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  CHANNEL    = 8'h01,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    ipClk,
  input  logic                    reset,
  input  UART_PACKET              ipRxStream,
  output logic                    opRxReady,
  output logic                    opWrEnable,
  output logic                    opRdEnable,
  output logic [ADDR_WIDTH-1:0]   opAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  input  logic [8*DATA_BYTES-1:0] ipRdData,
  input  logic                    ipRdValid,
  output UART_PACKET              opTxStream,
  input  logic                    ipTxReady
);

  localparam int unsigned W         = 8 * DATA_BYTES;
  localparam int unsigned AddrBytes = (ADDR_WIDTH + 7) / 8;

  state_e                state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d, word_cnt_q, word_cnt_d;
  logic [W-1:0]          word_q, word_d, wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rx_fire, start;
  logic [W-1:0]          word_shift;
  logic                  unused_rx;

  assign rx_fire    = ipRxStream.Valid && opRxReady;
  // A matching SoP always begins a new command, whatever state we are in.
  assign start      = rx_fire && ipRxStream.SoP && (ipRxStream.Source == CHANNEL);
  assign word_shift = W'({word_q, ipRxStream.Data});
  assign unused_rx  = ^{ipRxStream.Destination, ipRxStream.Length};

`ifdef UART_REG_READ_EN
  logic [7:0] count_q, count_d, total_q, total_d;
  logic       load, tx_done;
`endif

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
`ifdef UART_REG_READ_EN
    count_d    = count_q;
    total_d    = total_q;
    load       = 1'b0;
    if (state_q == StReadReq) addr_d = addr_q + 1'b1;
`endif
    if (wr_en_q) addr_d = addr_q + 1'b1;

    if (start) begin
      byte_cnt_d = '0;
      word_cnt_d = '0;
      is_read_d  = 1'b0;
      if (ipRxStream.EoP) begin
        state_d = StIdle;
      end else if (ipRxStream.Data == OP_WRITE) begin
        state_d = StGetAddress;
`ifdef UART_REG_READ_EN
      end else if (ipRxStream.Data == OP_READ) begin
        state_d   = StGetAddress;
        is_read_d = 1'b1;
`endif
      end else begin
        state_d = StDiscard;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StGetAddress: if (rx_fire) begin
          addr_d     = ADDR_WIDTH'({addr_q, ipRxStream.Data});
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (ipRxStream.EoP) begin
            state_d = StIdle;
          end else if (byte_cnt_q == 8'(AddrBytes - 1)) begin
            byte_cnt_d = '0;
            state_d    = is_read_q ? StGetCount : StGetData;
          end
        end
        StGetData: if (rx_fire) begin
          word_d     = word_shift;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 8'(DATA_BYTES - 1)) begin
            wr_en_d    = 1'b1;
            wr_data_d  = word_shift;
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (!ipRxStream.EoP && word_cnt_q == 8'(MAX_BURST - 1)) state_d = StDiscard;
          end
          if (ipRxStream.EoP) state_d = StIdle;
        end
        StDiscard: if (rx_fire && ipRxStream.EoP) state_d = StIdle;
`ifdef UART_REG_READ_EN
        StGetCount: if (rx_fire) begin
          if (ipRxStream.Data == 8'h00) begin
            state_d = StIdle;
          end else begin
            count_d = (ipRxStream.Data > 8'(MAX_BURST)) ? 8'(MAX_BURST) : ipRxStream.Data;
            total_d = count_d;
            state_d = StReadReq;
          end
        end
        StReadReq:  state_d = StReadWait;
        StReadWait: if (ipRdValid) begin
          load    = 1'b1;
          state_d = StSendResp;
        end
        StSendResp: if (tx_done) begin
          count_d = count_q - 1'b1;
          state_d = (count_q == 8'd1) ? StIdle : StReadReq;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ipClk) begin
    if (reset) begin
      state_q    <= StIdle;
      is_read_q  <= 1'b0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
`ifdef UART_REG_READ_EN
      count_q    <= '0;
      total_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
`ifdef UART_REG_READ_EN
      count_q    <= count_d;
      total_q    <= total_d;
`endif
    end
  end

  assign opWrEnable = wr_en_q;
  assign opWrData   = wr_data_q;
  assign opAddress  = addr_q;

`ifdef UART_REG_READ_EN
  assign opRdEnable = (state_q == StReadReq);
  assign opRxReady  = !reset && !(state_q inside {StReadReq, StReadWait, StSendResp});

  uart_tx_serialiser #(
    .DATA_BYTES(DATA_BYTES),
    .CHANNEL   (CHANNEL)
  ) u_tx (
    .ipClk     (ipClk),
    .reset     (reset),
    .load_i    (load),
    .word_i    (ipRdData),
    .sop_i     (count_q == total_q),
    .eop_i     (count_q == 8'd1),
    .length_i  (8'(32'(total_q) * DATA_BYTES)),
    .ipTxReady (ipTxReady),
    .opTxStream(opTxStream),
    .done_o    (tx_done)
  );
`else
  logic unused_rd;
  assign unused_rd  = ^{ipRdData, ipRdValid, ipTxReady};
  assign opRdEnable = 1'b0;
  assign opRxReady  = !reset;
  assign opTxStream = '0;
`endif

endmodule

// File: doc/uart_reg_controller.md
# uart_reg_controller

Parametrised bridge from the UART packet stream to the register bus, supporting burst writes and, optionally, burst reads. It decodes command packets addressed to its channel into register-bus transactions. Writes use configurable word width, address width and auto-incrementing addresses. Read data goes back to the host as a UART_PACKET response stream. The block sits between the UART packetiser and the register file.

## Interface
- DATA_BYTES, 4: bytes per register word; bus width is 8*DATA_BYTES.
- ADDR_WIDTH, 8: register address width, 8..16.
- CHANNEL, 8'h01: Source value that selects this block.
- MAX_BURST, 16: maximum number of words per packet, 1..255.

- ipClk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ipRxStream  input  UART_PACKET  command stream; a byte is accepted on Valid && opRxReady.
- opRxReady  output  1  ready for ipRxStream.
- opWrEnable  output  1  one-cycle write strobe.
- opRdEnable  output  1  one-cycle read strobe.
- opAddress  output  ADDR_WIDTH  bus address.
- opWrData  output  8*DATA_BYTES  write data.
- ipRdData  input  8*DATA_BYTES  read data; sampled when ipRdValid is high.
- ipRdValid  input  1  read data valid.
- opTxStream  output  UART_PACKET  response stream.
- ipTxReady  input  1  downstream ready; a byte is consumed on opTxStream.Valid && ipTxReady.

## Operation
- **Packet format:** opcode byte, then address bytes MSB-first (ceil(ADDR_WIDTH/8) bytes, excess high bits dropped), then a payload.
  - Write (opcode 8'h00): payload is words, MSB-first, DATA_BYTES bytes each.
  - Read (opcode 8'h01): payload is one count byte.
- **IDLE:** waits for a byte with SoP && Source==CHANNEL; that byte is the opcode. Bytes without a matching SoP are consumed and ignored.
- **GET_ADDRESS:** shifts address bytes into the address register.
- **GET_DATA:** shifts each byte into the word register.
  - After the DATA_BYTES-th byte: pulse opWrEnable, present the word on opWrData, and increment opAddress after the strobe.
  - Address wraps modulo 2^ADDR_WIDTH.
- **Packet end:** EoP on a byte ends the packet, and that byte is still processed.
  - A partial word at EoP is discarded with no strobe.
  - An EoP on the opcode or address byte cancels the packet.
- **Mid-packet restart:** SoP && Source==CHANNEL in any non-IDLE receive state restarts, treating that byte as a new opcode.
- **Burst limit:** after MAX_BURST words, the rest of the packet is dropped in DISCARD (consume bytes until EoP).
- **Unknown opcode:** goes to DISCARD.
- **Read sequence:** READ_REQ -> READ_WAIT -> SEND_RESP, repeated count times, then IDLE.
  - READ_REQ pulses opRdEnable.
  - READ_WAIT holds until ipRdValid.
  - SEND_RESP emits DATA_BYTES bytes MSB-first.
- **Read count:** count 0 is a no-op with no response; counts above MAX_BURST are clamped.
- **Read addressing:** the address increments after each read, with the same wrap rule as writes.
- **Response packet fields:**
  - Source=CHANNEL, Destination=8'h00, Length=(count*DATA_BYTES) mod 256.
  - SoP on the first byte only; EoP on the final byte only.
- **opRxReady:** low from READ_REQ through the end of SEND_RESP; high otherwise.
- **Reset values:** every output is 0, including all opTxStream fields. State goes to IDLE and the burst counter is cleared.

## Timing
- Strobe latency: opWrEnable is high in the cycle after the last byte of a word is accepted.
- Back-to-back writes: one word per DATA_BYTES accepted bytes, with no added bubbles.
- opWrData and opAddress stay stable during the strobe. opAddress updates in the following cycle.
- Read strobe: opRdEnable is high the cycle after the count byte is accepted, or the cycle after a response word completes.
- First response byte: opTxStream.Valid rises the cycle after ipRdValid.
- Response stream: each byte is held until ipTxReady. Bytes stream back-to-back while ipTxReady stays high.
- Reset mid-operation: an in-flight word or response is abandoned and no strobe is issued. After reset, ipRdValid is ignored until the next READ_WAIT.
- Simultaneous SoP restart and final data byte: the restart wins, and no strobe is issued.

## Configuration
- UART_REG_READ_EN: when defined, the read path is compiled in (READ_* states, response stream).
- When undefined:
  - Opcode 8'h01 is treated as unknown and goes to DISCARD.
  - opRdEnable and opTxStream are tied to 0.
  - ipRdData, ipRdValid and ipTxReady are unused.
  - opRxReady is high whenever not in reset.

## Structure
- Shared package Structures:
  - Existing UART_PACKET.
  - New opcode constants OP_WRITE=8'h00, OP_READ=8'h01.
  - New state enum.
- Sub-module uart_tx_serialiser: takes a DATA_BYTES-wide word plus SoP/EoP flags and emits bytes with the ipTxReady handshake. It is used only under UART_REG_READ_EN.

## Test plan
- **Single write.** Stimulus: SoP 00, 10, DE AD BE EF with EoP. Response: one opWrEnable pulse; opAddress 8'h10; opWrData 32'hDEADBEEF.
- **Burst write with wrap.** Stimulus: address FF, 3 words 11111111/22222222/33333333. Response: strobes at FF, 00, 01; no gaps beyond 4 cycles per word.
- **Partial word and wrong channel.**
  - SoP 00, 20, AA BB with EoP: no strobe.
  - Same packet with Source 8'h02: no strobe.
- **Burst read.** Stimulus: 01, 40, count 02 with ipRdData 0xCAFEF00D then 0x12345678, and ipTxReady toggled. Response:
  - opRdEnable at 40 and 41.
  - Stream CA FE F0 0D 12 34 56 78, with SoP on the first byte and EoP on the last.
  - Length 8.
- **Restart and reset mid-packet.** Stimulus: write a 2-byte partial, then a new SoP 00, 05 packet. Response: only the new packet writes. Asserting reset during SEND_RESP zeros all outputs the next cycle.
- **Build without UART_REG_READ_EN.** Stimulus: read packet. Response: no opRdEnable; opTxStream stays 0; a following write works normally.
